// File: rtl/instr_mem_loader.sv
// Accepts 32-bit instruction words over valid/ready and writes each one into the
// byte-addressed instruction store as four little-endian byte writes.
module instr_mem_loader #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              word_valid_i,
    input  logic [31:0]       word_data_i,
    input  logic              word_last_i,
    output logic              word_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-2:0] word_count_o
);

    // state       | meaning
    // S_IDLE      | no session since reset; waiting for start
    // S_WAIT_WORD | session open, word_ready high, waiting for a word
    // S_WRITE     | writing byte bi_q of the buffered word
    // S_DONE      | session complete; done held until start or reset
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_WRITE     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);

    state_t            state_q, state_d;
    logic [1:0]        bi_q, bi_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       word_buf_q, word_buf_d;
    logic              last_buf_q, last_buf_d;
    logic [ADDR_W-2:0] count_q, count_d;
    logic              at_end;

    assign at_end       = (base_q == LAST_BASE);
    assign word_count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            bi_q       <= 2'd0;
            base_q     <= '0;
            word_buf_q <= 32'd0;
            last_buf_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            bi_q       <= bi_d;
            base_q     <= base_d;
            word_buf_q <= word_buf_d;
            last_buf_q <= last_buf_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bi_d         = bi_q;
        base_d       = base_q;
        word_buf_d   = word_buf_q;
        last_buf_d   = last_buf_q;
        count_d      = count_q;
        word_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = 8'd0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                if (start_i) begin
                    state_d = S_WAIT_WORD;
                    base_d  = '0;
                    count_d = '0;
                    bi_d    = 2'd0;
                end
            end
            S_WAIT_WORD: begin
                busy_o       = 1'b1;
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    word_buf_d = word_data_i;
                    last_buf_d = word_last_i;
                    bi_d       = 2'd0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_o   = 1'b1;
                mem_we_o = 1'b1;
                // base is word aligned, so the byte index fills the low two bits
                mem_addr_o = {base_q[ADDR_W-1:2], bi_q};
                case (bi_q)
                    2'd0:    mem_wdata_o = word_buf_q[7:0];
                    2'd1:    mem_wdata_o = word_buf_q[15:8];
                    2'd2:    mem_wdata_o = word_buf_q[23:16];
                    default: mem_wdata_o = word_buf_q[31:24];
                endcase
                bi_d = bi_q + 2'd1;
                if (bi_q == 2'd3) begin
                    count_d = count_q + 1'b1;
                    // base is held on the final word so it never wraps to 0
                    if (!at_end) begin
                        base_d = base_q + WORD_STEP;
                    end
                    if (last_buf_q || at_end) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_WORD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
